i2c_sensor_sequencer: RTL and testbench

Scan controller between the I2C master and the MLP classifier input stage. Periodically reads one 16-bit register from each of NUM_CH sensors through the I2C master's start/busy/done interface and assembles the words into one feature frame. It presents the frame to the MLP with a valid/ready handshake, substituting zeros and flagging any channel whose transaction times out.

---
 rtl/sensor_seq_pkg.sv | 22 ++
 rtl/i2c_sensor_sequencer_if.sv | 43 ++++
 rtl/seq_poll_timer.sv | 31 +++
 rtl/i2c_sensor_sequencer.sv | 171 +++++++++++++++++
 tb/tb_i2c_sensor_sequencer.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sensor_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sensor_seq_pkg
//  Purpose  : Shared types and constants for the I2C sensor scan sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package sensor_seq_pkg;

   localparam int CH_W            = 16;
   localparam int DEF_POLL_PERIOD = 5_000_000;
   localparam int DEF_TIMEOUT     = 200_000;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ISSUE     = 3'd1,
      ST_WAIT_DONE = 3'd2,
      ST_NEXT      = 3'd3,
      ST_PRESENT   = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/i2c_sensor_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_sensor_sequencer_if
//  Purpose  : Bundles the I2C master handshake, channel config and MLP frame port.
//  Revision : 1.0  initial release
// ============================================================================
interface i2c_sensor_sequencer_if
   import sensor_seq_pkg::*;
#(
   parameter int NUM_CH = 3
);
   logic                     enable;
   logic                     trig;
   logic [7*NUM_CH-1:0]      ch_dev_addr;
   logic [8*NUM_CH-1:0]      ch_reg_addr;
   logic                     i2c_start;
   logic [6:0]               i2c_dev_addr;
   logic [7:0]               i2c_reg_addr;
   logic                     i2c_busy;
   logic                     i2c_done;
   logic [CH_W-1:0]          i2c_read_data;
   logic [CH_W*NUM_CH-1:0]   frame_data;
   logic                     frame_valid;
   logic                     frame_ready;
   logic [NUM_CH-1:0]        err_mask;
   logic                     overrun;
   logic                     scan_active;

   modport master (
      input  enable, trig, ch_dev_addr, ch_reg_addr,
      input  i2c_busy, i2c_done, i2c_read_data, frame_ready,
      output i2c_start, i2c_dev_addr, i2c_reg_addr,
      output frame_data, frame_valid, err_mask, overrun, scan_active
   );

   modport slave (
      output enable, trig, ch_dev_addr, ch_reg_addr,
      output i2c_busy, i2c_done, i2c_read_data, frame_ready,
      input  i2c_start, i2c_dev_addr, i2c_reg_addr,
      input  frame_data, frame_valid, err_mask, overrun, scan_active
   );
endinterface
`default_nettype wire

// File: rtl/seq_poll_timer.sv
`default_nettype none
// ============================================================================
//  Module   : seq_poll_timer
//  Purpose  : Free-running down-counter emitting a one-cycle tick every PERIOD.
//  Revision : 1.0  initial release
// ============================================================================
module seq_poll_timer #(
   parameter int POLL_PERIOD = 5_000_000
) (
   input  wire logic clk,
   input  wire logic rst,
   output logic      o_tick
);
   localparam int CNT_W = $clog2(POLL_PERIOD);
   localparam logic [CNT_W-1:0] c_reload = CNT_W'(POLL_PERIOD - 1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= c_reload;
      end else if (r_cnt == '0) begin
         r_cnt <= c_reload;
      end else begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_tick = (r_cnt == '0);
endmodule
`default_nettype wire

// File: rtl/i2c_sensor_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_sensor_sequencer
//  Purpose  : Polls NUM_CH sensor registers over I2C and presents one frame to the MLP.
//  Revision : 1.0  initial release
// ============================================================================
module i2c_sensor_sequencer
   import sensor_seq_pkg::*;
#(
   parameter int NUM_CH      = 3,
   parameter int POLL_PERIOD = DEF_POLL_PERIOD,
   parameter int TIMEOUT     = DEF_TIMEOUT
) (
   input  wire logic               clk,
   input  wire logic               rst,
   i2c_sensor_sequencer_if.master  bus
);
   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int WD_W  = $clog2(TIMEOUT);
   localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_CH - 1);
   localparam logic [WD_W-1:0]  c_wd_limit = WD_W'(TIMEOUT - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [IDX_W-1:0]   r_ch_idx;
   logic [IDX_W-1:0]   w_issue_idx;
   logic [WD_W-1:0]    r_wdog;
   logic [6:0]         r_dev_addr;
   logic [6:0]         w_dev_sel;
   logic [7:0]         r_reg_addr;
   logic [7:0]         w_reg_sel;
   logic [CH_W-1:0]    r_slot [NUM_CH];
   logic [NUM_CH-1:0]  r_err_mask;
   logic               r_overrun;
   logic               w_tick;
   logic               w_req;
   logic               w_scan_start;
   logic               w_wd_exp;
   logic               w_capture;
   logic               w_timeout;
   logic               w_issue_entry;

   seq_poll_timer #(
      .POLL_PERIOD (POLL_PERIOD)
   ) u_poll_timer (
      .clk    (clk),
      .rst    (rst),
      .o_tick (w_tick)
   );

   assign w_req        = (w_tick & bus.enable) | bus.trig;
   assign w_scan_start = (r_state == ST_IDLE) && w_req;
   assign w_wd_exp     = (r_wdog == c_wd_limit);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_req) w_state_nxt = ST_ISSUE;
         end
         ST_ISSUE: begin
            // start is held until the master acknowledges with busy
            if (bus.i2c_busy) begin
               w_state_nxt = ST_WAIT_DONE;
            end else if (w_wd_exp) begin
               w_timeout   = 1'b1;
               w_state_nxt = ST_NEXT;
            end
         end
         ST_WAIT_DONE: begin
            if (bus.i2c_done) begin
               w_capture   = 1'b1;
               w_state_nxt = ST_NEXT;
            end else if (w_wd_exp) begin
               w_timeout   = 1'b1;
               w_state_nxt = ST_NEXT;
            end
         end
         ST_NEXT: begin
            w_state_nxt = (r_ch_idx == c_last_idx) ? ST_PRESENT : ST_ISSUE;
         end
         ST_PRESENT: begin
            if (bus.frame_ready) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_issue_entry = (w_state_nxt == ST_ISSUE) && (r_state != ST_ISSUE);
   assign w_issue_idx   = (r_state == ST_IDLE) ? '0 : r_ch_idx + 1'b1;

   always_comb begin
      w_dev_sel = '0;
      w_reg_sel = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (w_issue_idx == IDX_W'(k)) begin
            w_dev_sel = bus.ch_dev_addr[7*k +: 7];
            w_reg_sel = bus.ch_reg_addr[8*k +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ch_idx   <= '0;
         r_wdog     <= '0;
         r_dev_addr <= '0;
         r_reg_addr <= '0;
         r_err_mask <= '0;
         r_overrun  <= 1'b0;
         for (int k = 0; k < NUM_CH; k++) r_slot[k] <= '0;
      end else begin
         if (w_scan_start) begin
            r_ch_idx <= '0;
         end else if ((r_state == ST_NEXT) && (r_ch_idx != c_last_idx)) begin
            r_ch_idx <= r_ch_idx + 1'b1;
         end

         // watchdog restarts on every state change so each wait phase gets a full budget
         if (w_state_nxt != r_state) begin
            r_wdog <= '0;
         end else if ((r_state == ST_ISSUE) || (r_state == ST_WAIT_DONE)) begin
            r_wdog <= r_wdog + 1'b1;
         end

         if (w_issue_entry) begin
            r_dev_addr <= w_dev_sel;
            r_reg_addr <= w_reg_sel;
         end

         if (w_scan_start) r_err_mask <= '0;

         for (int k = 0; k < NUM_CH; k++) begin
            if (r_ch_idx == IDX_W'(k)) begin
               if (w_capture) begin
                  r_slot[k] <= bus.i2c_read_data;
               end else if (w_timeout) begin
                  r_slot[k]     <= '0;
                  r_err_mask[k] <= 1'b1;
               end
            end
         end

         if ((r_state != ST_IDLE) && w_req) r_overrun <= 1'b1;
      end
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_frame
      assign bus.frame_data[CH_W*k +: CH_W] = r_slot[k];
   end

   assign bus.i2c_start    = (r_state == ST_ISSUE);
   assign bus.i2c_dev_addr = r_dev_addr;
   assign bus.i2c_reg_addr = r_reg_addr;
   assign bus.frame_valid  = (r_state == ST_PRESENT);
   assign bus.err_mask     = r_err_mask;
   assign bus.overrun      = r_overrun;
   assign bus.scan_active  = (r_state == ST_ISSUE) || (r_state == ST_WAIT_DONE) ||
                             (r_state == ST_NEXT);
endmodule
`default_nettype wire

// File: tb/tb_i2c_sensor_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_sensor_sequencer
//  Purpose  : Scoreboard bench with a behavioural I2C master for the scan sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_i2c_sensor_sequencer;
   import sensor_seq_pkg::*;

   localparam int NUM_CH = 3;
   localparam int POLL   = 5000;
   localparam int TMO    = 1000;
   localparam logic [47:0] c_frame_ok = {16'h0F0F, 16'hABCD, 16'h1234};

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   i2c_sensor_sequencer_if #(.NUM_CH(NUM_CH)) bus ();

   i2c_sensor_sequencer #(
      .NUM_CH      (NUM_CH),
      .POLL_PERIOD (POLL),
      .TIMEOUT     (TMO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks   = 0;
   int n_errors   = 0;
   int n_accepted = 0;
   int n_starts   = 0;
   int busy_delay = 3;
   logic [6:0] no_done_dev = 7'h7F;

   logic [47:0] exp_data_q [$];
   logic [2:0]  exp_err_q  [$];
   logic [14:0] exp_addr_q [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: event not expected or not seen in time", name);
   endtask

   function automatic logic [15:0] rdata_for(input logic [6:0] dev);
      case (dev)
         7'h40:   rdata_for = 16'h1234;
         7'h44:   rdata_for = 16'hABCD;
         7'h76:   rdata_for = 16'h0F0F;
         default: rdata_for = 16'hDEAD;
      endcase
   endfunction

   task automatic push_addrs(input int n);
      logic [14:0] tbl [3];
      tbl[0] = {7'h40, 8'h01};
      tbl[1] = {7'h44, 8'h00};
      tbl[2] = {7'h76, 8'hFA};
      for (int i = 0; i < n; i++) exp_addr_q.push_back(tbl[i]);
   endtask

   task automatic push_scan(input logic [47:0] d, input logic [2:0] e);
      push_addrs(3);
      exp_data_q.push_back(d);
      exp_err_q.push_back(e);
   endtask

   task automatic pulse_trig();
      @(posedge clk); #1 bus.trig = 1'b1;
      @(posedge clk); #1 bus.trig = 1'b0;
   endtask

   task automatic wait_accepted(input int target, input int budget);
      int c = 0;
      while ((n_accepted < target) && (c < budget)) begin
         @(posedge clk); #1;
         c++;
      end
      check("frames_accepted", 64'(n_accepted), 64'(target));
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_start"},     64'(bus.i2c_start),    64'(0));
      check({tag, "_dev_addr"},  64'(bus.i2c_dev_addr), 64'(0));
      check({tag, "_reg_addr"},  64'(bus.i2c_reg_addr), 64'(0));
      check({tag, "_frame"},     64'(bus.frame_data),   64'(0));
      check({tag, "_err_mask"},  64'(bus.err_mask),     64'(0));
      check({tag, "_valid"},     64'(bus.frame_valid),  64'(0));
      check({tag, "_overrun"},   64'(bus.overrun),      64'(0));
      check({tag, "_active"},    64'(bus.scan_active),  64'(0));
   endtask

   // behavioural I2C master: acknowledges start after busy_delay cycles, then returns data
   initial begin : master
      logic [14:0] got;
      logic [14:0] exp;
      logic [6:0]  dev;
      bus.i2c_busy      = 1'b0;
      bus.i2c_done      = 1'b0;
      bus.i2c_read_data = '0;
      forever begin
         @(posedge clk); #1;
         if (bus.i2c_start && !bus.i2c_busy) begin
            n_starts++;
            dev = bus.i2c_dev_addr;
            got = {bus.i2c_dev_addr, bus.i2c_reg_addr};
            if (exp_addr_q.size() == 0) begin
               fail_now("start_addr_unexpected");
            end else begin
               exp = exp_addr_q.pop_front();
               check("start_addr", 64'(got), 64'(exp));
            end
            repeat (busy_delay - 1) begin @(posedge clk); #1; end
            bus.i2c_busy = 1'b1;
            repeat (20) begin @(posedge clk); #1; end
            if (dev != no_done_dev) begin
               bus.i2c_done      = 1'b1;
               bus.i2c_read_data = rdata_for(dev);
               @(posedge clk); #1;
               bus.i2c_done      = 1'b0;
               bus.i2c_read_data = '0;
            end
            bus.i2c_busy = 1'b0;
         end
      end
   end

   initial begin : start_mon
      int   run;
      logic prev_start;
      logic prev_busy;
      run = 0; prev_start = 1'b0; prev_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.i2c_start) begin
            run++;
         end else begin
            if (prev_start && !rst) begin
               check("start_hold_cycles", 64'(run), 64'(busy_delay));
               check("start_drop_after_busy", 64'(prev_busy), 64'(1));
            end
            run = 0;
         end
         prev_start = bus.i2c_start;
         prev_busy  = bus.i2c_busy;
      end
   end

   initial begin : frame_mon
      logic [47:0] prev_data;
      logic [47:0] ed;
      logic [2:0]  ee;
      logic        prev_valid;
      logic        prev_ready;
      prev_data = '0; prev_valid = 1'b0; prev_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (prev_valid && !prev_ready && !rst) begin
            check("valid_held", 64'(bus.frame_valid), 64'(1));
            check("frame_stable", 64'(bus.frame_data), 64'(prev_data));
         end
         if (bus.frame_valid && bus.frame_ready) begin
            n_accepted++;
            if (exp_data_q.size() == 0) begin
               fail_now("frame_unexpected");
            end else begin
               ed = exp_data_q.pop_front();
               ee = exp_err_q.pop_front();
               check("frame_data", 64'(bus.frame_data), 64'(ed));
               check("err_mask", 64'(bus.err_mask), 64'(ee));
            end
         end
         prev_data  = bus.frame_data;
         prev_valid = bus.frame_valid;
         prev_ready = bus.frame_ready;
      end
   end

   initial begin : stim
      int c;
      int starts_before;
      int acc_before;
      bus.enable      = 1'b0;
      bus.trig        = 1'b0;
      bus.frame_ready = 1'b1;
      bus.ch_dev_addr = {7'h76, 7'h44, 7'h40};
      bus.ch_reg_addr = {8'hFA, 8'h00, 8'h01};
      repeat (3) @(posedge clk);
      #1 check_reset_values("por");
      rst = 1'b0;

      // normal scan
      push_scan(c_frame_ok, 3'b000);
      pulse_trig();
      wait_accepted(1, 2000);

      // slow start acceptance
      busy_delay = 300;
      push_scan(c_frame_ok, 3'b000);
      pulse_trig();
      wait_accepted(2, 3000);
      busy_delay = 3;

      // channel 1 never completes
      no_done_dev = 7'h44;
      push_scan({16'h0F0F, 16'h0000, 16'h1234}, 3'b010);
      pulse_trig();
      wait_accepted(3, 3000);

      // reset while waiting on channel 1
      push_addrs(2);
      pulse_trig();
      c = 0;
      while (!(bus.i2c_start && bus.i2c_dev_addr == 7'h44) && c < 500) begin
         @(posedge clk); #1; c++;
      end
      while (bus.i2c_start && c < 1000) begin
         @(posedge clk); #1; c++;
      end
      if (c >= 1000) fail_now("midscan_reach_wait_done");
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      #1 check_reset_values("midscan");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("addr_q_after_reset", 64'(exp_addr_q.size()), 64'(0));
      no_done_dev = 7'h7F;
      repeat (100) @(posedge clk);
      #1;
      push_scan(c_frame_ok, 3'b000);
      pulse_trig();
      wait_accepted(4, 2000);

      // periodic scanning disabled
      starts_before = n_starts;
      repeat (3 * POLL) @(posedge clk);
      #1;
      check("disabled_no_scan", 64'(n_starts), 64'(starts_before));
      push_scan(c_frame_ok, 3'b000);
      pulse_trig();
      wait_accepted(5, 2000);
      check("overrun_clear", 64'(bus.overrun), 64'(0));

      // backpressure with periodic scanning
      bus.frame_ready = 1'b0;
      push_scan(c_frame_ok, 3'b000);
      bus.enable = 1'b1;
      c = 0;
      while (!bus.frame_valid && c < POLL + 500) begin
         @(posedge clk); #1; c++;
      end
      check("bp_valid_seen", 64'(bus.frame_valid), 64'(1));
      acc_before = n_accepted;
      repeat (20000) @(posedge clk);
      #1;
      check("bp_overrun", 64'(bus.overrun), 64'(1));
      check("bp_valid_still", 64'(bus.frame_valid), 64'(1));
      bus.enable      = 1'b0;
      bus.frame_ready = 1'b1;
      repeat (50) @(posedge clk);
      #1;
      check("bp_one_accept", 64'(n_accepted), 64'(acc_before + 1));
      check("bp_valid_low", 64'(bus.frame_valid), 64'(0));

      check("exp_frames_left", 64'(exp_data_q.size()), 64'(0));
      check("exp_addrs_left", 64'(exp_addr_q.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
